// File: rtl/gtype.sv
// Shared XGMII types, control codes and frame-boundary helpers for the frame switch.
package gtype;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  ctrl;
    } xgmii32_t;

    localparam xgmii32_t   XGMII_IDLE_WORD = '{data: 32'h0707_0707, ctrl: 4'hF};
    localparam logic [7:0] XGMII_START_B   = 8'hFB;
    localparam logic [7:0] XGMII_TERM_B    = 8'hFD;
    localparam logic [7:0] XGMII_ERR_B     = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_FWD,
        ST_DRAIN
    } sw_state_e;

    // A Start is only ever carried in lane 0.
    function automatic logic is_start(input xgmii32_t w);
        return w.ctrl[0] && (w.data[7:0] == XGMII_START_B);
    endfunction

    // A Terminate may sit in any lane.
    function automatic logic has_term(input xgmii32_t w);
        logic t;
        t = 1'b0;
        for (int l = 0; l < 4; l++) begin
            if (w.ctrl[l] && (w.data[8*l +: 8] == XGMII_TERM_B)) begin
                t = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/xgmii_frame_switch_port.sv
// One switch output: source mux, frame-boundary FSM and forwarded-frame counter.
module xgmii_frame_switch_port
    import gtype::*;
#(
    parameter int NUM_IN = 2,
    parameter int SEL_W  = $clog2(NUM_IN + 1),
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  xgmii32_t [NUM_IN-1:0]    xgmii_in_i,
    input  logic     [SEL_W-1:0]     sel_i,
    input  logic                     sel_vld_i,
    output xgmii32_t                 xgmii_out_o,
    output logic                     active_o,
    output logic     [CNT_W-1:0]     frame_cnt_o
);

    // Any select at or above NUM_IN means "disconnected"; NUM_IN itself is the canonical value.
    localparam logic [SEL_W-1:0] SRC_NONE = SEL_W'(NUM_IN);

    sw_state_e        state_q, state_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic             in_frm_q, in_frm_d;
    xgmii32_t         out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    xgmii32_t         src_word;
    logic             fwd_en;
    logic             sel_ok;
    logic             leave;
    logic [SEL_W-1:0] leave_tgt;

    assign sel_ok = (sel_i < SRC_NONE);

    // Pick the word of the current source; a disconnected source reads as IDLE.
    always_comb begin
        src_word = XGMII_IDLE_WORD;
        for (int i = 0; i < NUM_IN; i++) begin
            if (src_q == SEL_W'(i)) begin
                src_word = xgmii_in_i[i];
            end
        end
    end

    // State register plus all registered datapath state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_NONE;
            pend_q   <= SRC_NONE;
            in_frm_q <= 1'b0;
            out_q    <= XGMII_IDLE_WORD;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            pend_q   <= pend_d;
            in_frm_q <= in_frm_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: decides where we go and whether this cycle's source word is forwarded.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        pend_d    = pend_q;
        fwd_en    = 1'b0;
        leave     = 1'b0;
        leave_tgt = SRC_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_vld_i && sel_ok) begin
                    state_d = ST_WAIT_SOF;
                    src_d   = sel_i;
                end
            end
            ST_WAIT_SOF: begin
                // A new request retargets; the word seen in that cycle is not inspected.
                if (sel_vld_i) begin
                    leave     = 1'b1;
                    leave_tgt = sel_i;
                end else if (is_start(src_word)) begin
                    fwd_en  = 1'b1;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                fwd_en = 1'b1;
                if (sel_vld_i && (sel_i != src_q)) begin
                    if (!in_frm_q && !is_start(src_word)) begin
                        fwd_en    = 1'b0;
                        leave     = 1'b1;
                        leave_tgt = sel_i;
                    end else if (has_term(src_word)) begin
                        leave     = 1'b1;
                        leave_tgt = sel_i;
                    end else begin
                        pend_d  = sel_i;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                fwd_en = 1'b1;
                if (sel_vld_i) begin
                    pend_d = sel_i;
                end
                if (has_term(src_word)) begin
                    leave     = 1'b1;
                    leave_tgt = sel_vld_i ? sel_i : pend_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                src_d   = SRC_NONE;
            end
        endcase
        if (leave) begin
            pend_d = SRC_NONE;
            if (leave_tgt < SRC_NONE) begin
                state_d = ST_WAIT_SOF;
                src_d   = leave_tgt;
            end else begin
                state_d = ST_IDLE;
                src_d   = SRC_NONE;
            end
        end
    end

    // Output logic: forwarded word or IDLE, frame counting and in-frame tracking.
    always_comb begin
        out_d    = XGMII_IDLE_WORD;
        cnt_d    = cnt_q;
        in_frm_d = in_frm_q;
        if (fwd_en) begin
            out_d = src_word;
            if (is_start(src_word)) begin
                cnt_d    = cnt_q + CNT_W'(1);
                in_frm_d = 1'b1;
            end else if (has_term(src_word)) begin
                in_frm_d = 1'b0;
            end
        end
    end

    assign xgmii_out_o = out_q;
    assign active_o    = (state_q == ST_FWD) || (state_q == ST_DRAIN);
    assign frame_cnt_o = cnt_q;

endmodule

// File: rtl/xgmii_frame_switch.sv
// Frame-aware XGMII 32-bit crossbar: NUM_IN sources to NUM_OUT independent outputs.
module xgmii_frame_switch
    import gtype::*;
#(
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2,
    parameter int SEL_W   = $clog2(NUM_IN + 1),
    parameter int CNT_W   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  xgmii32_t [NUM_IN-1:0]              xgmii_in,
    input  logic     [NUM_OUT-1:0][SEL_W-1:0]  sel,
    input  logic     [NUM_OUT-1:0]             sel_vld,
    output xgmii32_t [NUM_OUT-1:0]             xgmii_out,
    output logic     [NUM_OUT-1:0]             out_active,
    output logic     [NUM_OUT-1:0][CNT_W-1:0]  frame_cnt
);

    // Outputs never interact, so each gets its own port instance seeing every input.
    for (genvar o = 0; o < NUM_OUT; o++) begin : g_port
        xgmii_frame_switch_port #(
            .NUM_IN (NUM_IN),
            .SEL_W  (SEL_W),
            .CNT_W  (CNT_W)
        ) u_port (
            .clk_i       (clk),
            .rst_ni      (rst),
            .xgmii_in_i  (xgmii_in),
            .sel_i       (sel[o]),
            .sel_vld_i   (sel_vld[o]),
            .xgmii_out_o (xgmii_out[o]),
            .active_o    (out_active[o]),
            .frame_cnt_o (frame_cnt[o])
        );
    end

endmodule

// File: tb/tb_xgmii_frame_switch.sv
// Randomized self-checking bench for xgmii_frame_switch against a frame-level reference model.
module tb_xgmii_frame_switch;
    import gtype::*;

    localparam int NIN  = 2;
    localparam int NOUT = 2;
    localparam int SELW = 2;
    localparam int CNTW = 4;

    logic                          clk;
    logic                          rst;
    xgmii32_t [NIN-1:0]            xgmiiIn;
    logic     [NOUT-1:0][SELW-1:0] sel;
    logic     [NOUT-1:0]           selVld;
    xgmii32_t [NOUT-1:0]           xgmiiOut;
    logic     [NOUT-1:0]           outActive;
    logic     [NOUT-1:0][CNTW-1:0] frameCnt;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: which source is being forwarded (-1 none), which one we want next,
    // whether a switch is waiting for the current frame to finish, and the frame count.
    int       mCur[NOUT];
    int       mWant[NOUT];
    int       mPend[NOUT];
    int       mCnt[NOUT];
    bit       mInFrm[NOUT];
    bit       mDrain[NOUT];
    bit       mAct[NOUT];
    xgmii32_t mOut[NOUT];

    int genLeft[NIN];

    xgmii_frame_switch #(
        .NUM_IN  (NIN),
        .NUM_OUT (NOUT),
        .SEL_W   (SELW),
        .CNT_W   (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .xgmii_in   (xgmiiIn),
        .sel        (sel),
        .sel_vld    (selVld),
        .xgmii_out  (xgmiiOut),
        .out_active (outActive),
        .frame_cnt  (frameCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed %h, required %h at %0t", tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    function automatic bit modelIsStart(input xgmii32_t w);
        return (w.ctrl[0] == 1'b1) && (w.data[7:0] == 8'hFB);
    endfunction

    function automatic bit modelHasTerm(input xgmii32_t w);
        for (int l = 0; l < 4; l++) begin
            if (w.ctrl[l] && (w.data[8*l +: 8] == 8'hFD)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int wantOf(input int s);
        return (s < NIN) ? s : -1;
    endfunction

    task automatic modelReset();
        for (int o = 0; o < NOUT; o++) begin
            mCur[o] = -1; mWant[o] = -1; mPend[o] = -1; mCnt[o] = 0;
            mInFrm[o] = 1'b0; mDrain[o] = 1'b0; mAct[o] = 1'b0;
            mOut[o] = XGMII_IDLE_WORD;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        xgmii32_t word;
        bit       gone;
        int       s;
        for (int o = 0; o < NOUT; o++) begin
            s = int'(sel[o]);
            mOut[o] = XGMII_IDLE_WORD;
            if (mCur[o] < 0) begin
                if (selVld[o]) begin
                    mWant[o] = wantOf(s);
                end else if (mWant[o] >= 0 && modelIsStart(xgmiiIn[mWant[o]])) begin
                    mOut[o]   = xgmiiIn[mWant[o]];
                    mCnt[o]   = (mCnt[o] + 1) % (1 << CNTW);
                    mInFrm[o] = 1'b1;
                    mCur[o]   = mWant[o];
                end
            end else begin
                word = xgmiiIn[mCur[o]];
                gone = 1'b0;
                if (!mDrain[o]) begin
                    if (selVld[o] && s != mCur[o]) begin
                        if (!mInFrm[o] && !modelIsStart(word)) begin
                            mCur[o]  = -1;
                            mWant[o] = wantOf(s);
                            gone     = 1'b1;
                        end else begin
                            mDrain[o] = 1'b1;
                            mPend[o]  = s;
                        end
                    end
                end else if (selVld[o]) begin
                    mPend[o] = s;
                end
                if (!gone) begin
                    mOut[o] = word;
                    if (modelIsStart(word)) begin
                        mCnt[o]   = (mCnt[o] + 1) % (1 << CNTW);
                        mInFrm[o] = 1'b1;
                    end else if (modelHasTerm(word)) begin
                        mInFrm[o] = 1'b0;
                    end
                    if (mDrain[o] && modelHasTerm(word)) begin
                        mCur[o]   = -1;
                        mWant[o]  = wantOf(mPend[o]);
                        mDrain[o] = 1'b0;
                    end
                end
            end
            mAct[o] = (mCur[o] >= 0);
        end
    endtask

    task automatic checkAll(input string phase);
        for (int o = 0; o < NOUT; o++) begin
            checkOutput($sformatf("%s xgmii_out[%0d]", phase, o), 64'(xgmiiOut[o]), 64'(mOut[o]));
            checkOutput($sformatf("%s out_active[%0d]", phase, o), 64'(outActive[o]), 64'(mAct[o]));
            checkOutput($sformatf("%s frame_cnt[%0d]", phase, o), 64'(frameCnt[o]), 64'(mCnt[o]));
        end
    endtask

    task automatic applyStimulus(input string phase);
        modelStep();
        @(posedge clk);
        #1;
        checkAll(phase);
    endtask

    function automatic xgmii32_t mkStart();
        xgmii32_t   w;
        logic [31:0] r;
        r = $urandom();
        w.data = {r[31:8], 8'hFB};
        w.ctrl = 4'b0001;
        return w;
    endfunction

    function automatic xgmii32_t mkData();
        xgmii32_t w;
        w.data = $urandom();
        w.ctrl = 4'b0000;
        return w;
    endfunction

    function automatic xgmii32_t mkTerm(input int lane);
        xgmii32_t w;
        w.data = $urandom();
        w.ctrl = 4'b0000;
        for (int b = lane; b < 4; b++) begin
            w.data[8*b +: 8] = (b == lane) ? 8'hFD : 8'h07;
            w.ctrl[b] = 1'b1;
        end
        return w;
    endfunction

    function automatic xgmii32_t mkErr(input int lane);
        xgmii32_t w;
        w.data = $urandom();
        w.ctrl = 4'b0000;
        w.data[8*lane +: 8] = XGMII_ERR_B;
        w.ctrl[lane] = 1'b1;
        return w;
    endfunction

    // Per-input frame generator: idle gaps, Start, a few data/error words, Terminate.
    task automatic genWord(input int i, output xgmii32_t w);
        if (genLeft[i] < 0) begin
            if ($urandom_range(0, 3) == 0) begin
                w = mkStart();
                genLeft[i] = $urandom_range(0, 6);
            end else begin
                w = XGMII_IDLE_WORD;
            end
        end else if (genLeft[i] > 0) begin
            w = ($urandom_range(0, 15) == 0) ? mkErr($urandom_range(0, 3)) : mkData();
            genLeft[i]--;
        end else begin
            w = mkTerm($urandom_range(0, 3));
            genLeft[i] = -1;
        end
    endtask

    task automatic midReset();
        #3;
        rst = 1'b0;
        #1;
        modelReset();
        checkAll("async reset");
        @(posedge clk);
        #1;
        checkAll("held reset");
        rst = 1'b1;
    endtask

    initial begin
        xgmii32_t w;
        rst     = 1'b0;
        sel     = '0;
        selVld  = '0;
        xgmiiIn = {XGMII_IDLE_WORD, XGMII_IDLE_WORD};
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        rst = 1'b1;

        // Both outputs pick input 0 and see one complete frame.
        sel[0] = 2'd0; sel[1] = 2'd0; selVld = 2'b11;
        applyStimulus("select0");
        selVld = 2'b00;
        xgmiiIn[0] = mkStart();   applyStimulus("frame start");
        repeat (3) begin xgmiiIn[0] = mkData(); applyStimulus("frame data"); end
        xgmiiIn[0] = mkTerm(1);   applyStimulus("frame term");
        xgmiiIn[0] = XGMII_IDLE_WORD; applyStimulus("frame gap");

        // Output 0 moves to input 1 while input 1 is mid-frame: the partial frame is dropped.
        xgmiiIn[1] = mkData(); sel[0] = 2'd1; selVld = 2'b01;
        applyStimulus("join midframe");
        selVld = 2'b00;
        xgmiiIn[1] = mkData();    applyStimulus("skip data");
        xgmiiIn[1] = mkTerm(0);   applyStimulus("skip term");
        xgmiiIn[1] = XGMII_IDLE_WORD; applyStimulus("skip gap");
        xgmiiIn[1] = mkStart();   applyStimulus("new start");
        xgmiiIn[1] = mkData();    applyStimulus("new data");

        // Two requests while draining (back to 0, then disconnect): frame completes, then IDLE.
        xgmiiIn[1] = mkData(); xgmiiIn[0] = mkStart(); sel[0] = 2'd0; selVld = 2'b01;
        applyStimulus("drain req0");
        xgmiiIn[1] = mkData(); xgmiiIn[0] = mkData(); sel[0] = 2'd2;
        applyStimulus("drain disc");
        selVld = 2'b00;
        xgmiiIn[1] = mkTerm(3); xgmiiIn[0] = mkTerm(2); applyStimulus("drain term");
        xgmiiIn[1] = XGMII_IDLE_WORD; xgmiiIn[0] = mkStart(); applyStimulus("after disc");
        xgmiiIn[0] = mkTerm(0);   applyStimulus("after disc2");
        xgmiiIn[0] = XGMII_IDLE_WORD; applyStimulus("after disc3");

        // Randomized traffic with random requests; the small counter wraps many times.
        genLeft[0] = 2;
        genLeft[1] = 4;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NIN; i++) begin
                genWord(i, w);
                xgmiiIn[i] = w;
            end
            for (int o = 0; o < NOUT; o++) begin
                selVld[o] = ($urandom_range(0, 11) == 0);
                sel[o]    = SELW'($urandom_range(0, 3));
            end
            applyStimulus("random");
            if (c == 1500 || c == 3100) begin
                midReset();
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
